axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
Parametrised AXI4-Lite master. It converts a single-outstanding command/response stream into AXI4-Lite write or read transactions. This is the successor to the fixed-pattern write-then-read master. It adds:
- configurable address and data width;
- independent AW/W handshakes;
- BRESP/RRESP capture;
- a response timeout.

It sits between a local controller (CPU bridge, test sequencer) and the AXI4-Lite interconnect.

Parameters:
ADDR_W, 32, address width of cmd_addr/awaddr/araddr
DATA_W, 32, data width; must be 32 or 64; strobe width = DATA_W/8
TIMEOUT_CYCLES, 1024, cycles allowed per transaction before forced completion; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI response code
rsp_timeout  out  1  transaction ended by timeout
awaddr  out  ADDR_W  /  awvalid  out  1  /  awready  in  1
wdata  out  DATA_W  /  wstrb  out  DATA_W/8  /  wvalid  out  1  /  wready  in  1
bresp  in  2  /  bvalid  in  1  /  bready  out  1
araddr  out  ADDR_W  /  arvalid  out  1  /  arready  in  1
rdata  in  DATA_W  /  rresp  in  2  /  rvalid  in  1  /  rready  out  1

Behaviour:
Reset (async, immediate, including mid-transaction):
- state = IDLE;
- all valid/ready outputs 0 except cmd_ready;
- all data, address, resp and strobe outputs 0;
- rsp_timeout 0;
- timeout counter 0.
- cmd_ready is decoded from the state register only (state == IDLE), so it is 1 during reset.

States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.

- IDLE: on cmd_valid && cmd_ready, latch the address, data and strobes into the AXI output registers.
  - Write: awvalid = wvalid = 1 next cycle; go to WR_AW_W.
  - Read: arvalid = 1 next cycle; go to RD_AR.
- WR_AW_W: awvalid and wvalid drop independently, on the edge where their own ready is sampled high. AW and W may complete in the same cycle or in either order.
  - When both are complete (including a simultaneous final handshake): bready = 1, go to WR_B.
- WR_B: on bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, drop bready, set rsp_valid = 1, go to RSP.
- RD_AR: on arready, drop arvalid, set rready = 1, go to RD_R.
- RD_R: on rvalid, capture rdata/rresp, drop rready, set rsp_valid = 1, go to RSP.
- RSP: rsp_valid and the response fields stay stable until rsp_ready; then rsp_valid = 0 and go to IDLE.
  - The next command can be accepted the cycle after the return to IDLE.

Handshake rules:
- Valids, once asserted, are held with stable payload until their handshake, except on timeout or reset.
- bready/rready are 0 outside WR_B/RD_R; stray bvalid/rvalid is ignored.

Latency with an always-ready slave (command accepted at edge 0):
- AW/W valid in cycle 1;
- bready in cycle 2, B handshake in cycle 2;
- rsp_valid in cycle 3.
- Reads have the same latency.

Timeout:
- The counter clears on command acceptance and increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
- When the count reaches TIMEOUT_CYCLES - 1 without completion:
  - force all AXI valids/readies to 0;
  - set rsp_resp = 2'b10 (SLVERR), rsp_timeout = 1, rsp_rdata = 0;
  - go to RSP.
- If completion and timeout occur in the same cycle, completion wins and rsp_timeout = 0.
- rsp_timeout clears when the response is consumed.
- The counter saturates and never wraps.
- The counter width is clog2(TIMEOUT_CYCLES + 1).

Decomposition:
- axi_lite_pkg holds:
  - the resp_t enum (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3);
  - the master state_t enum;
  - a localparam function for strobe width.
- One sub-module, axi_timeout_ctr: parameter TIMEOUT_CYCLES; ports clear, enable, expired. It is tied off to expired = 0 when TIMEOUT_CYCLES = 0.

Test Plan:
1. Write addr 0x10, data 0x12345678, strb 0xF, slave always ready, bresp = OKAY -> awvalid/wvalid high in cycle 1; rsp_valid in cycle 3 with rsp_resp = 0, rsp_timeout = 0.
2. Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid is held with awaddr stable until handshake; exactly one B accepted.
3. Read addr 0x20, rdata 0xDEADBEEF, rresp = 2'b11, rsp_ready low for 4 cycles -> rsp_rdata = 0xDEADBEEF, rsp_resp = 3, held stable for 4 cycles; cmd_ready low until consumed.
4. TIMEOUT_CYCLES = 8, slave never asserts arready -> arvalid drops after 8 cycles in RD_AR; rsp_resp = 2, rsp_timeout = 1; the next read completes normally.
5. Reset asserted during WR_B with bvalid pending -> all AXI valid/ready outputs 0 immediately; cmd_ready = 1 after release; bvalid ignored in IDLE.
6. DATA_W = 64, ADDR_W = 40: write wstrb 0xF0 at addr 0x1_0000_0008 -> wstrb/awaddr propagate at full width; response OKAY.

Source files
------------

// File: rtl/axi_lite_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared types for the AXI4-Lite command master: AXI response
//                codes, master state encoding and the strobe width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  // One strobe bit per data byte.
  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_cmd_master_if
//  Description : Command/response stream plus AXI4-Lite bus seen by the
//                command master. "master" is the DUT view, "slave" is the
//                view of the controller and interconnect around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_cmd_master_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = strb_width(DATA_W);

  // Command / response stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  // AXI4-Lite channels
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
           awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
           awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready
  );

endinterface
`default_nettype wire

// File: rtl/axi_lite_cmd_master_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_timeout_ctr
//  Description : Saturating per-transaction cycle counter. expired is high
//                once the count has reached TIMEOUT_CYCLES-1. A zero
//                TIMEOUT_CYCLES removes the counter entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over increment; stop at SAT so the count never wraps.
    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable && (count_q != SAT)) begin
        count_d = count_q + 1'b1;
      end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
    end

    // >= keeps expired asserted after saturation past the limit.
    assign expired = (count_q >= LIMIT);
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_cmd_master
//  Description : Single-outstanding command/response to AXI4-Lite master
//                with independent AW/W handshakes, response capture and a
//                per-transaction timeout. DATA_W must be 32 or 64.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_lite_cmd_master_if.master bus
);
  localparam int STRB_W = strb_width(DATA_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic              bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d, timeout_q, timeout_d;
  resp_t             resp_q, resp_d;

  logic accept, abort, busy, expired, aw_fin, w_fin;

  assign busy   = (state_q == ST_WR_AW_W) || (state_q == ST_WR_B) ||
                  (state_q == ST_RD_AR)   || (state_q == ST_RD_R);
  // A channel is finished if already handshaken or handshaking this cycle.
  assign aw_fin = !awvalid_q || bus.awready;
  assign w_fin  = !wvalid_q  || bus.wready;

  axi_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (busy),
    .expired (expired)
  );

  // Next-state and registered-output decode; a phase completion beats timeout.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d   = timeout_q;
    resp_d      = resp_q;
    accept      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_write) begin
            awaddr_d  = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_AW_W;
          end else begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_AR;
          end
        end
      end
      ST_WR_AW_W: begin
        if (aw_fin && w_fin) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = ST_WR_B;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          if (bus.awready) awvalid_d = 1'b0;
          if (bus.wready)  wvalid_d  = 1'b0;
        end
      end
      ST_WR_B: begin
        if (bus.bvalid) begin
          resp_d      = resp_t'(bus.bresp);
          rdata_d     = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b0;
          state_d     = ST_RSP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_AR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_R: begin
        if (bus.rvalid) begin
          resp_d      = resp_t'(bus.rresp);
          rdata_d     = bus.rdata;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b0;
          state_d     = ST_RSP;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      resp_d      = SLVERR;
      rdata_d     = '0;
      timeout_d   = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = ST_RSP;
    end
  end

  // State and output registers; reset clears everything mid-transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      resp_q      <= OKAY;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
      resp_q      <= resp_d;
    end
  end

  // cmd_ready comes straight from the state register so it is high in reset.
  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_resp    = resp_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.awaddr      = awaddr_q;
  assign bus.awvalid     = awvalid_q;
  assign bus.wdata       = wdata_q;
  assign bus.wstrb       = wstrb_q;
  assign bus.wvalid      = wvalid_q;
  assign bus.bready      = bready_q;
  assign bus.araddr      = araddr_q;
  assign bus.arvalid     = arvalid_q;
  assign bus.rready      = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_cmd_master
//  Description : Self-checking bench for axi_lite_cmd_master (40-bit address,
//                64-bit data, TIMEOUT_CYCLES = 8). Expected timing comes from
//                cycle arithmetic on the slave delays, counted from the
//                command acceptance edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 8;
  localparam int NEVER = 99;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_cmd_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
  endtask

  // One command; a/w = AW/W (or AR) ready delays, d = B/R delay after the
  // address phase(s); NEVER means the slave never responds on that channel.
  task automatic txn(input string nm, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input logic [SW-1:0] strb,
                     input int a, input int w, input int d, input logic [1:0] resp,
                     input logic [DW-1:0] rdat, input int hold);
    int cyc = 0, rsp_cyc = -1, aw_hi = 0, w_hi = 0, ar_hi = 0, b_hi = 0, r_hi = 0;
    int aw_c = -1, w_c = -1, ar_c = -1, pay_bad = 0, busy_bad = 0, hold_bad = 0;
    int mx, fin, exp_cyc, exp_p1, exp_p2;
    bit got = 0, b_done = 0, r_done = 0, exp_to;
    logic idle_bad = 1'b0;
    logic [DW-1:0] c_rdata = '0;
    logic [1:0] c_resp = 2'b00;
    logic c_to = 1'b0;

    // Reference: final handshake cycle relative to acceptance (cycle 0).
    mx      = (a > w) ? a : w;
    fin     = wr ? (mx + 2 + d) : (a + 2 + d);
    exp_to  = (fin > TO);
    exp_cyc = exp_to ? TO + 1 : fin + 1;
    exp_p1  = (a + 1 <= TO) ? a + 1 : TO;
    exp_p2  = exp_to ? (wr ? TO - 1 - mx : TO - 1 - a) : d + 1;
    if (exp_p2 < 0) exp_p2 = 0;

    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = data; bus.cmd_wstrb = strb; bus.rsp_ready = 1'b0;
    chk({nm, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));

    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.cmd_valid = 1'b0;
      slave_idle();
      if (bus.cmd_ready !== 1'b0) busy_bad++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1; rsp_cyc = cyc;
        c_rdata = bus.rsp_rdata; c_resp = bus.rsp_resp; c_to = bus.rsp_timeout;
        idle_bad = bus.awvalid | bus.wvalid | bus.bready | bus.arvalid | bus.rready;
      end else begin
        if (bus.awvalid === 1'b1) begin
          aw_hi++;
          if (bus.awaddr !== addr) pay_bad++;
          if (cyc >= 1 + a) begin bus.awready = 1'b1; aw_c = cyc; end
        end
        if (bus.wvalid === 1'b1) begin
          w_hi++;
          if (bus.wdata !== data || bus.wstrb !== strb) pay_bad++;
          if (cyc >= 1 + w) begin bus.wready = 1'b1; w_c = cyc; end
        end
        if (bus.bready === 1'b1) b_hi++;
        if (wr && aw_c >= 0 && w_c >= 0 && !b_done &&
            cyc >= ((aw_c > w_c) ? aw_c : w_c) + 1 + d) begin
          bus.bvalid = 1'b1; bus.bresp = resp;
          if (bus.bready === 1'b1) b_done = 1;
        end
        if (bus.arvalid === 1'b1) begin
          ar_hi++;
          if (bus.araddr !== addr) pay_bad++;
          if (cyc >= 1 + a) begin bus.arready = 1'b1; ar_c = cyc; end
        end
        if (bus.rready === 1'b1) r_hi++;
        if (!wr && ar_c >= 0 && !r_done && cyc >= ar_c + 1 + d) begin
          bus.rvalid = 1'b1; bus.rdata = rdat; bus.rresp = resp;
          if (bus.rready === 1'b1) r_done = 1;
        end
      end
    end

    chk({nm, "_rsp_cycle"}, 64'(rsp_cyc), 64'(exp_cyc));
    chk({nm, "_rdata"}, c_rdata, (wr || exp_to) ? '0 : rdat);
    chk({nm, "_resp"}, 64'(c_resp), exp_to ? 64'(SLVERR) : 64'(resp));
    chk({nm, "_timeout"}, 64'(c_to), 64'(exp_to));
    chk({nm, "_payload_stable"}, 64'(pay_bad), 64'(0));
    chk({nm, "_cmd_ready_busy"}, 64'(busy_bad), 64'(0));
    chk({nm, "_axi_idle_at_rsp"}, 64'(idle_bad), 64'(0));
    if (wr) begin
      chk({nm, "_awvalid_cycles"}, 64'(aw_hi), 64'(a + 1));
      chk({nm, "_wvalid_cycles"}, 64'(w_hi), 64'(w + 1));
      chk({nm, "_bready_cycles"}, 64'(b_hi), 64'(exp_p2));
    end else begin
      chk({nm, "_arvalid_cycles"}, 64'(ar_hi), 64'(exp_p1));
      chk({nm, "_rready_cycles"}, 64'(r_hi), 64'(exp_p2));
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== c_rdata || bus.rsp_resp !== c_resp ||
          bus.rsp_timeout !== c_to || bus.cmd_ready !== 1'b0) hold_bad++;
    end
    chk({nm, "_rsp_hold"}, 64'(hold_bad), 64'(0));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({nm, "_consumed"}, 64'({bus.rsp_valid, bus.rsp_timeout, bus.cmd_ready}), 64'(3'b001));
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data, r_rdat;

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
    slave_idle();

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_handshakes", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                              bus.rready, bus.rsp_valid, bus.rsp_timeout}), 64'(0));
    chk("rst_addr", 64'({bus.awaddr, bus.araddr}), 64'(0));
    chk("rst_data", {bus.wdata ^ bus.rsp_rdata}, 64'(0));
    chk("rst_strb_resp", 64'({bus.wstrb, bus.rsp_resp}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios.
    txn("t1_write_basic", 1'b1, 40'h10, 64'h1234_5678, 8'h0F, 0, 0, 0, 2'b00, '0, 0);
    txn("t2_aw_late", 1'b1, 40'h44, 64'hA5A5_0001, 8'h0F, 3, 0, 0, 2'b00, '0, 1);
    txn("t2b_w_late", 1'b1, 40'h48, 64'hA5A5_0002, 8'h03, 0, 2, 1, 2'b01, '0, 0);
    txn("t3_read_hold", 1'b0, 40'h20, '0, '0, 0, 0, 0, 2'b11, 64'hDEAD_BEEF, 4);
    txn("t4_ar_timeout", 1'b0, 40'h30, '0, '0, NEVER, 0, 0, 2'b00, 64'h1, 1);
    txn("t4_read_after", 1'b0, 40'h34, '0, '0, 0, 0, 1, 2'b00, 64'hCAFE_F00D, 0);
    txn("bnd_r_last_cycle", 1'b0, 40'h38, '0, '0, 0, 0, 6, 2'b01, 64'h77, 0);
    txn("bnd_r_one_late", 1'b0, 40'h3C, '0, '0, 0, 0, 7, 2'b01, 64'h88, 0);
    txn("bnd_b_never", 1'b1, 40'h50, 64'h9, 8'hFF, 0, 0, NEVER, 2'b00, '0, 2);

    // Reset during WR_B with bvalid pending.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 40'h60;
    bus.cmd_wdata = 64'h55; bus.cmd_wstrb = 8'h01;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    @(posedge clk); #1;
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("t5_in_wr_b", 64'(bus.bready), 64'(1));
    bus.bvalid = 1'b1; bus.bresp = 2'b01;
    #2 reset = 1'b1;
    #1;
    chk("t5_async_outputs", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                                bus.rready, bus.rsp_valid, bus.rsp_timeout}), 64'(0));
    chk("t5_async_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_stray_bvalid_%0d", i),
          64'({bus.bready, bus.rsp_valid, bus.cmd_ready}), 64'(3'b001));
    end
    slave_idle();

    // Full-width write.
    txn("t6_wide_write", 1'b1, 40'h1_0000_0008, 64'hFEDC_BA98_7654_3210, 8'hF0,
        0, 0, 0, 2'b00, '0, 0);

    // Randomized transactions within the no-timeout envelope.
    for (int i = 0; i < 16; i++) begin
      r_addr = AW'({$urandom, $urandom});
      r_data = {$urandom, $urandom};
      r_rdat = {$urandom, $urandom};
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), r_addr, r_data,
          8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 2)), 2'($urandom), r_rdat, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
